// File: rtl/regfile_write_arbiter.sv
// Single-write-port arbiter for registerFile: WB has fixed priority over the LT valid/ready producer.
// Define REGARB_STARVE_EN to add the LT wait counter, the one-cycle STALL state and the wb_lost flag.
module regfile_write_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        wb_float,
    input  logic        lt_valid,
    output logic        lt_ready,
    input  logic [4:0]  lt_reg,
    input  logic [31:0] lt_data,
    input  logic        lt_float,
    output logic        stall_req,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        regWrite,
    output logic        float,
    output logic        wb_lost
);

    logic        in_stall;
    logic        wb_grant;
    logic        lt_grant;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wflt_q, wflt_d;
    logic        wen_q, wen_d;

    // While stalled the pipeline is expected to be quiet, so LT owns the port.
    assign lt_ready = in_stall | ~wb_valid;
    assign wb_grant = wb_valid & ~in_stall;
    assign lt_grant = lt_valid & lt_ready;

    always_comb begin
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        wflt_d  = wflt_q;
        wen_d   = 1'b0;
        if (wb_grant) begin
            wreg_d  = wb_reg;
            wdata_d = wb_data;
            wflt_d  = wb_float;
            wen_d   = (wb_reg != 5'd0);
        end else if (lt_grant) begin
            wreg_d  = lt_reg;
            wdata_d = lt_data;
            wflt_d  = lt_float;
            wen_d   = (lt_reg != 5'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
            wflt_q  <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            wflt_q  <= wflt_d;
            wen_q   <= wen_d;
        end
    end

    assign writeReg  = wreg_q;
    assign writeData = wdata_q;
    assign float     = wflt_q;
    assign regWrite  = wen_q;

`ifdef REGARB_STARVE_EN
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    typedef enum logic {
        NORMAL = 1'b0,
        STALL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       wb_lost_q, wb_lost_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wb_lost_d  = wb_lost_q;
        case (state_q)
            NORMAL: begin
                if (lt_valid && !lt_ready) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = STALL;
                        wait_cnt_d = 4'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = 4'd0;
                end
            end
            STALL: begin
                // Either LT is accepted now or it withdrew; both end the stall.
                state_d    = NORMAL;
                wait_cnt_d = 4'd0;
                if (wb_valid) begin
                    wb_lost_d = 1'b1;
                end
            end
            default: begin
                state_d    = NORMAL;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NORMAL;
            wait_cnt_q <= 4'd0;
            wb_lost_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wb_lost_q  <= wb_lost_d;
        end
    end

    assign in_stall  = (state_q == STALL);
    assign stall_req = in_stall;
    assign wb_lost   = wb_lost_q;
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;

    assign in_stall  = 1'b0;
    assign stall_req = 1'b0;
    assign wb_lost   = 1'b0;
`endif

endmodule
